data_in_64_to_8: RTL

Parallel 64-bit to byte-stream serializer. It accepts one 64-bit word per load handshake and feeds its eight bytes, least-significant byte first, to the UART transmitter one at a time, waiting for the transmitter's per-byte completion before sending the next. It sits on the transmit path and is the counterpart of the 8-to-64 byte collector on the receive path. Byte order matches that collector, so a looped-back word is reassembled unchanged.

---
 rtl/data_in_64_to_8.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_in_64_to_8.sv
// -----------------------------------------------------------------------------
// data_in_64_to_8
//
// Purpose
//   Parallel 64-bit to byte-stream serializer for the UART transmit path.
//   It accepts one 64-bit word per load handshake. The eight bytes are sent
//   least-significant byte first to the UART transmitter, one byte at a time.
//   The next byte is not started until the transmitter reports completion of
//   the current one. The byte order matches the 8-to-64 collector on the
//   receive path, so a word that is looped back is reassembled unchanged.
//
// Parameters
//   WAIT_CYCLES   idle clk cycles inserted between a byte's tx_done rising
//                 edge and the next tx_start (0..65535).
//
// Build option
//   CHECKSUM_BYTE_EN  when defined, a ninth byte is sent after byte 7. It is
//                     the XOR of the eight data bytes, captured at load
//                     acceptance. When undefined, no checksum logic exists.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   data_64        in  64   word to transmit, sampled only on an accepted load
//   load           in   1   load request
//   tx_done        in   1   per-byte completion from the transmitter (edge used)
//   ready          out  1   idle and able to accept a load
//   data_8         out  8   byte presented to the transmitter
//   tx_start       out  1   one-cycle pulse: transmitter latches data_8
//   transmit_done  out  1   one-cycle pulse after the final byte completes
//   state_dbg      out  3   current FSM state (debug observation only)
//
// Handshakes
//   load/ready : a word is transferred on a rising clk edge where load=1 and
//                ready=1. While ready=0, load is ignored and data_64 is not
//                sampled. ready remains low from the cycle after acceptance
//                until the cycle after transmit_done.
//   tx_start/tx_done : tx_start is a single-cycle pulse with data_8 valid. The
//                byte counts as complete on the first cycle in which tx_done
//                is high after being low (a rising edge). A level held high
//                counts once. Edges are ignored outside the WAIT state.
// -----------------------------------------------------------------------------
module data_in_64_to_8 #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_64,
  input  logic        load,
  input  logic        tx_done,
  output logic        ready,
  output logic [7:0]  data_8,
  output logic        tx_start,
  output logic        transmit_done,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Number of bytes sent per word.
`ifdef CHECKSUM_BYTE_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif

  // Some gap is needed only when WAIT_CYCLES is nonzero. The terminal count
  // is guarded so that it does not wrap when WAIT_CYCLES is 0.
  localparam bit          HAS_GAP  = (WAIT_CYCLES != 0);
  localparam logic [15:0] GAP_LAST = HAS_GAP ? 16'(WAIT_CYCLES - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [63:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic        tx_done_d;
  logic        tx_edge;

  logic        ready_d;
  logic [7:0]  data_8_d;
  logic        tx_start_d;
  logic        transmit_done_d;

  // Byte shifted into the top of the shift register on each completed byte.
  // With the checksum enabled, this is the registered checksum. After eight
  // shifts it therefore arrives at shift_q[7:0] as the ninth byte.
  logic [7:0]  fill_byte;

`ifdef CHECKSUM_BYTE_EN
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  chk_calc;

  assign chk_calc = data_64[7:0]   ^ data_64[15:8]  ^ data_64[23:16] ^
                    data_64[31:24] ^ data_64[39:32] ^ data_64[47:40] ^
                    data_64[55:48] ^ data_64[63:56];
  assign fill_byte = chk_q;
`else
  assign fill_byte = 8'h00;
`endif

  // tx_done_d follows tx_done in every state. An edge is therefore visible
  // only on the first high cycle, even if that cycle falls outside WAIT.
  assign tx_edge   = tx_done & ~tx_done_d;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shift_q       <= 64'd0;
      cnt_q         <= 4'd0;
      gap_q         <= 16'd0;
      tx_done_d     <= 1'b0;
      ready         <= 1'b1;
      data_8        <= 8'h00;
      tx_start      <= 1'b0;
      transmit_done <= 1'b0;
`ifdef CHECKSUM_BYTE_EN
      chk_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      tx_done_d     <= tx_done;
      ready         <= ready_d;
      data_8        <= data_8_d;
      tx_start      <= tx_start_d;
      transmit_done <= transmit_done_d;
`ifdef CHECKSUM_BYTE_EN
      chk_q         <= chk_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // Outputs are computed for the state being entered. For example, tx_start
  // rises in the first cycle of SEND, and transmit_done in the only cycle of
  // DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    cnt_d           = cnt_q;
    gap_d           = gap_q;
    ready_d         = ready;
    data_8_d        = data_8;
    tx_start_d      = 1'b0;
    transmit_done_d = 1'b0;
`ifdef CHECKSUM_BYTE_EN
    chk_d           = chk_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A load takes precedence. Any tx_done edge in this cycle is ignored.
        if (load) begin
          shift_d    = data_64;
          cnt_d      = 4'd0;
          ready_d    = 1'b0;
          tx_start_d = 1'b1;
          data_8_d   = data_64[7:0];
          state_d    = ST_SEND;
`ifdef CHECKSUM_BYTE_EN
          chk_d      = chk_calc;
`endif
        end
      end

      ST_SEND: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (tx_edge) begin
          shift_d = {fill_byte, shift_q[63:8]};
          cnt_d   = 4'(cnt_q + 4'd1);
          if (cnt_d == LAST) begin
            transmit_done_d = 1'b1;
            state_d         = ST_DONE;
          end else if (!HAS_GAP) begin
            tx_start_d = 1'b1;
            data_8_d   = shift_d[7:0];
            state_d    = ST_SEND;
          end else begin
            gap_d   = 16'd0;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        // GAP lasts exactly WAIT_CYCLES cycles. The next byte is already at
        // shift_q[7:0], because the shift happened when GAP was entered.
        if (gap_q == GAP_LAST) begin
          tx_start_d = 1'b1;
          data_8_d   = shift_q[7:0];
          state_d    = ST_SEND;
        end else begin
          gap_d = 16'(gap_q + 16'd1);
        end
      end

      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
